// File: rtl/data_memory_pkg.sv
// data_memory_pkg: DMOp encodings, default word count and width helpers shared with the controller
package data_memory_pkg;
    typedef enum logic [2:0] {
        DM_WORD  = 3'b000,
        DM_BYTE  = 3'b001,
        DM_BYTEU = 3'b010,
        DM_HALF  = 3'b011,
        DM_HALFU = 3'b100
    } dm_op_t;
    localparam int DM_WORDS_DEF = 3072;
    function automatic logic is_byte(input logic [2:0] op);
        return op == DM_BYTE || op == DM_BYTEU;
    endfunction
    function automatic logic is_half(input logic [2:0] op);
        return op == DM_HALF || op == DM_HALFU;
    endfunction
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: load/store bus between the datapath (master) and data memory (slave)
//   PC    instruction address, used only for the write log
//   Addr  byte address
//   WD    store data
//   WE    store enable
//   DMOp  access width/extension
//   RD    extended load data
//   AdErr address error for the current access
interface data_memory_if;
    logic [31:0] PC;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic        WE;
    logic [2:0]  DMOp;
    logic [31:0] RD;
    logic        AdErr;
    modport master (output PC, Addr, WD, WE, DMOp, input RD, AdErr);
    modport slave (input PC, Addr, WD, WE, DMOp, output RD, AdErr);
endinterface

// File: rtl/dm_lane_ext.sv
// dm_lane_ext: merges store data into the addressed word and extracts/extends load data
//   word   current array word
//   wd     store data
//   off    byte offset Addr[1:0]
//   op     DMOp
//   merged word to write back
//   rd     extracted, extended load data
// Subword lanes exist only when DM_SUBWORD_EN is defined; otherwise word-only pass-through.
module dm_lane_ext
    import data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wd,
    input  logic [1:0]  off,
    input  logic [2:0]  op,
    output logic [31:0] merged,
    output logic [31:0] rd
);
`ifdef DM_SUBWORD_EN
    logic [31:0] bmask;
    logic [31:0] hmask;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        bmask = 32'hff << {off, 3'b000};
        hmask = off[1] ? 32'hffff_0000 : 32'h0000_ffff;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        // replicate the subword across all lanes, then let the mask pick the addressed one
        merged = is_byte(op) ? (word & ~bmask) | ({4{wd[7:0]}} & bmask)
               : is_half(op) ? (word & ~hmask) | ({2{wd[15:0]}} & hmask)
               : wd;
        rd = op == DM_BYTE  ? {{24{b[7]}}, b}
           : op == DM_BYTEU ? {24'h0, b}
           : op == DM_HALF  ? {{16{h[15]}}, h}
           : op == DM_HALFU ? {16'h0, h}
           : word;
    end
`else
    logic unused_sel;
    assign unused_sel = ^{off, op};
    assign merged = wd;
    assign rd = word;
`endif
endmodule

// File: rtl/data_memory.sv
// data_memory: word-organised data RAM with combinational reads, checked stores and a write log
//   clk    rising-edge clock
//   reset  synchronous active-high; clears every word, wins over a concurrent store
//   bus    data_memory_if.slave (PC, Addr, WD, WE, DMOp in; RD, AdErr out)
// Build option: define DM_SUBWORD_EN for byte/halfword access; without it only word ops are legal.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF
) (
    input logic          clk,
    input logic          reset,
    data_memory_if.slave bus
);
    localparam int AW = $clog2(DM_WORDS);
    logic [31:0]   mem [DM_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   merged;
    logic [31:0]   ext;
    logic          legal;
    logic          misalign;
    logic          oor;
    logic          aderr;
    assign idx = bus.Addr[AW+1:2];
    always_comb begin
`ifdef DM_SUBWORD_EN
        legal = bus.DMOp <= DM_HALFU;
        misalign = bus.DMOp == DM_WORD ? |bus.Addr[1:0] : is_half(bus.DMOp) & bus.Addr[0];
`else
        legal = bus.DMOp == DM_WORD;
        misalign = |bus.Addr[1:0];
`endif
        oor = bus.Addr >= 32'(4 * DM_WORDS);
        aderr = !legal || misalign || oor;
    end
    dm_lane_ext u_ext (
        .word   (mem[idx]),
        .wd     (bus.WD),
        .off    (bus.Addr[1:0]),
        .op     (bus.DMOp),
        .merged (merged),
        .rd     (ext)
    );
    // an out-of-range index is harmless here: aderr forces RD to 0 and blocks the write
    assign bus.RD = aderr ? '0 : ext;
    assign bus.AdErr = aderr;
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
        end else if (bus.WE && !aderr) begin
            mem[idx] <= merged;
        end
    end
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && bus.WE && !aderr)
            $display("@%08h: *%08h <= %08h", bus.PC, {bus.Addr[31:2], 2'b00}, merged);
    end
`endif
endmodule
